mem_port_arbiter: RTL and testbench

Round-robin arbiter that owns one FFT memory bank port and drives the 4-bit select of the bank's 8:1 address/data mux. Up to eight requesters (input loader, butterfly read/write ports, output unloader, etc.) raise requests; the arbiter grants one at a time, holds the grant for a burst, and rotates fairly. Select value 8 is the idle code; on it the downstream mux deasserts chip enable and parks the address.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter owning one FFT memory bank port. Drives the 4-bit
//   select of the bank's 8:1 address/data mux; SEL_IDLE parks the mux.
//   A grant is held for a burst and released on a request drop or on a beat
//   with req_last. On release the next requester is granted on the very next
//   edge (no idle bubble), scanning from the released index + 1.
//
//   Optional feature macro: ARB_BURST_LIMIT_EN
//     defined   - a grant is force-released on the beat that brings beat_cnt
//                 to MAX_BURST.
//     undefined - no cap; beat_cnt saturates at 255.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   [7:0] per-requester request
//   req_last  in   [7:0] last-beat marker, honoured only for the granted bit
//   gnt       out  [7:0] one-hot grant, registered, zero when idle
//   sel       out  [3:0] registered mux select (0..7 or SEL_IDLE)
//   busy      out  high while a grant is active
//   beat_cnt  out  [7:0] beats completed in the current grant
//
// State table
//   IDLE  | no grant; sel = SEL_IDLE, scanning req from ptr
//   GRANT | requester sel[2:0] owns the port, counting beats

module mem_port_arbiter #(
    parameter int          NUM_REQ   = 8,
    parameter int          MAX_BURST = 16,
    parameter logic [3:0]  SEL_IDLE  = 4'd8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [3:0]         sel,
    output logic               busy,
    output logic [7:0]         beat_cnt
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be within 1..255");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t             state, state_next;
    logic [2:0]         ptr, ptr_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [3:0]         sel_next;
    logic               busy_next;
    logic [7:0]         cnt_next;

    logic [2:0]         g;
    logic               beat;
    logic               cap_hit;
    logic               release_now;
    logic [NUM_REQ-1:0] scan_req;
    logic [2:0]         scan_start;
    logic [3:0]         scan_res;

    // Returns {found, index}; the loop runs from the farthest offset down so
    // the nearest set bit to 'start' is the last one written and wins.
    function automatic logic [3:0] rr_scan(input logic [NUM_REQ-1:0] r,
                                           input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign g    = sel[2:0];
    assign beat = (state == GRANT) && req[g];

`ifdef ARB_BURST_LIMIT_EN
    assign cap_hit = beat && (beat_cnt == 8'(MAX_BURST - 1));
`else
    assign cap_hit = 1'b0;
`endif

    assign release_now = (state == GRANT) && (!req[g] || (beat && req_last[g]) || cap_hit);

    // A dropping requester is masked out of the rescan; one that finished with
    // req_last or the cap stays eligible but sits last in scan order.
    always_comb begin
        scan_req   = req;
        scan_start = ptr;
        if (state == GRANT) begin
            scan_start = g + 3'd1;
            if (!beat) scan_req = req & ~gnt;
        end
    end

    assign scan_res = rr_scan(scan_req, scan_start);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt;
        sel_next   = sel;
        busy_next  = busy;
        cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (scan_res[3]) begin
                    state_next = GRANT;
                    gnt_next   = ONE_HOT0 << scan_res[2:0];
                    sel_next   = {1'b0, scan_res[2:0]};
                    busy_next  = 1'b1;
                    cnt_next   = 8'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_next = g + 3'd1;
                    cnt_next = 8'd0;
                    if (scan_res[3]) begin
                        gnt_next = ONE_HOT0 << scan_res[2:0];
                        sel_next = {1'b0, scan_res[2:0]};
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        sel_next   = SEL_IDLE;
                        busy_next  = 1'b0;
                    end
                end else if (beat && beat_cnt != 8'd255) begin
                    cnt_next = beat_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                sel_next   = SEL_IDLE;
                busy_next  = 1'b0;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            gnt      <= '0;
            sel      <= SEL_IDLE;
            busy     <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            gnt      <= gnt_next;
            sel      <= sel_next;
            busy     <= busy_next;
            beat_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req_last;
    logic [7:0] gnt;
    logic [3:0] sel;
    logic       busy;
    logic [7:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .NUM_REQ   (8),
        .MAX_BURST (16),
        .SEL_IDLE  (4'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_last (req_last),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs settle #1 after the active edge; inputs are driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_sel 8 means idle: gnt 0, busy 0.
    task automatic check_grant(input string tag, input int exp_sel);
        logic [7:0] exp_gnt;
        exp_gnt = (exp_sel == 8) ? 8'h00 : (8'h01 << exp_sel);
        check({tag, ".sel"},  32'(sel),  32'(exp_sel));
        check({tag, ".gnt"},  32'(gnt),  32'(exp_gnt));
        check({tag, ".busy"}, 32'(busy), (exp_sel == 8) ? 32'd0 : 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 8'hFF;
        req_last = 8'h00;

        // reset held 3 cycles with all requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("rst_hold", 8);
            check("rst_hold.cnt", 32'(beat_cnt), 32'd0);
        end
        rst = 1'b0;
        check_grant("rst_fall", 8);
        tick();
        check_grant("first_grant", 0);
        check("first_grant.cnt", 32'(beat_cnt), 32'd0);

        // drop request 0 -> idle, ptr becomes 1
        req = 8'h00;
        tick();
        check_grant("drop0_idle", 8);

        // single burst on requester 3, req_last on the 4th beat
        req = 8'h08;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_grant("burst3", 3);
            check("burst3.cnt", 32'(beat_cnt), 32'(k));
            req_last = (k == 3) ? 8'h08 : 8'h00;
            tick();
        end
        req_last = 8'h00;
        // still requesting and alone: regranted with a fresh count
        check_grant("burst3_regrant", 3);
        check("burst3_regrant.cnt", 32'(beat_cnt), 32'd0);
        req = 8'h00;
        tick();
        check_grant("burst3_idle", 8);
        check("burst3_idle.cnt", 32'(beat_cnt), 32'd0);

        // ptr is 4: with 0 and 4 requesting, 4 wins
        req = 8'h11;
        tick();
        check_grant("ptr4", 4);
        // 4 drops, 5 picked up without a bubble
        req = 8'h20;
        tick();
        check_grant("handoff5", 5);
        // 5 drops, ptr = 6: 6 wins over 0
        req = 8'h41;
        tick();
        check_grant("wrap6", 6);
        req_last = 8'h40;
        tick();
        req_last = 8'h00;
        check_grant("wrap0", 0);

        // rotation between 0 and 7 with req_last every beat
        req      = 8'h81;
        req_last = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            check_grant("rotate", (i % 2 == 0) ? 0 : 7);
            tick();
        end
        req      = 8'h00;
        req_last = 8'h00;
        tick();
        check_grant("rotate_idle", 8);

        // requesters 2 and 5 held, no req_last (ptr = 1)
        req = 8'h24;
        tick();
`ifdef ARB_BURST_LIMIT_EN
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int c = 0; c < 16; c++) begin
                check_grant("cap", (rnd % 2 == 0) ? 2 : 5);
                check("cap.cnt", 32'(beat_cnt), 32'(c));
                tick();
            end
        end
`else
        for (int c = 0; c < 300; c++) begin
            check_grant("nocap", 2);
            if (c < 2 || (c > 252 && c < 258) || c == 299)
                check("nocap.cnt", 32'(beat_cnt), (c > 255) ? 32'd255 : 32'(c));
            tick();
        end
`endif
        req = 8'h00;
        tick();
        check_grant("cap_idle", 8);

        // mid-burst drop of requester 1 with 4 pending
        req = 8'h02;
        tick();
        check_grant("drop1_beat1", 1);
        req = 8'h12;
        tick();
        check_grant("drop1_beat2", 1);
        check("drop1_beat2.cnt", 32'(beat_cnt), 32'd1);
        req = 8'h10;
        tick();
        check_grant("after_drop", 4);
        check("after_drop.cnt", 32'(beat_cnt), 32'd0);
        tick();
        check("beat2_of_4.cnt", 32'(beat_cnt), 32'd1);
        tick();
        check_grant("beat3_of_4", 4);
        check("beat3_of_4.cnt", 32'(beat_cnt), 32'd2);
        rst = 1'b1;
        tick();
        check_grant("mid_rst", 8);
        check("mid_rst.cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0;
        req = 8'h00;
        tick();
        check_grant("post_rst", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
